kb_dir_queue: RTL and testbench

Keyboard command stage between `ps2keyboard` and the snake game FSM. Consumes completed PS/2 scan bytes, tracks make/break and E0-extended prefixes, and decodes W/A/S/D and arrow keys into 2-bit directions and Enter into a start pulse. Directions go into a small FIFO, one entry applied per game tick, so fast key sequences are not lost. Reversals and duplicates are rejected before queuing.

---
 rtl/kb_dir_queue.sv | 163 ++++++++++++++++
 tb/tb_kb_dir_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kb_dir_queue.sv
// kb_dir_queue: PS/2 scan-byte parser feeding a small direction FIFO for the
// snake game. Decodes W/A/S/D, arrow keys and Enter, filters duplicates and
// reversals, and releases one queued direction per game tick.
//
// Event semantics: there is no valid/ready handshake here. A byte is consumed
// exactly once, on the cycle the synchronized GotCode shows a 1->0 transition;
// the game tick `step` is a one-cycle pulse that pops at most one entry, and
// the keyboard side is never back-pressured (rejected keys pulse `drop`).
module kb_dir_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          CLOCK_50,
  input  logic          rst,
  input  logic [7:0]    SC0,
  input  logic          GotCode,
  input  logic          step,
  input  logic          clear,
  output logic [1:0]    dir,
  output logic          start,
  output logic [CW-1:0] pending,
  output logic          drop
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  logic          got_q1, got_q2, got_q3;
  logic          byte_evt;
  logic [1:0]    state, state_nxt;
  logic          key_vld, key_start;
  logic [1:0]    key_dir;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, tail_idx;
  logic [1:0]    ref_dir;
  logic          full, is_dup, is_rev, push, pop, reject;

  // GotCode is asynchronous: two synchronizer stages plus one for edge detect.
  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      got_q1 <= 1'b1;
      got_q2 <= 1'b1;
      got_q3 <= 1'b1;
    end else begin
      got_q1 <= GotCode;
      got_q2 <= got_q1;
      got_q3 <= got_q2;
    end
  end

  // Falling edge of the synchronized strobe marks a completed scan byte.
  assign byte_evt = got_q3 & ~got_q2;

  // Prefix tracking and key decode for the current byte event.
  always_comb begin
    state_nxt = state;
    key_vld   = 1'b0;
    key_dir   = DIR_UP;
    key_start = 1'b0;
    if (byte_evt) begin
      case (state)
        ST_IDLE: begin
          case (SC0)
            8'hE0: state_nxt = ST_EXT;
            8'hF0: state_nxt = ST_BRK;
            8'h1D: begin key_vld = 1'b1; key_dir = DIR_UP;    end
            8'h1B: begin key_vld = 1'b1; key_dir = DIR_DOWN;  end
            8'h1C: begin key_vld = 1'b1; key_dir = DIR_LEFT;  end
            8'h23: begin key_vld = 1'b1; key_dir = DIR_RIGHT; end
            8'h5A: key_start = 1'b1;
            default: ;
          endcase
        end
        ST_EXT: begin
          case (SC0)
            8'hF0: state_nxt = ST_EXT_BRK;
            8'hE0: state_nxt = ST_EXT;
            default: begin
              state_nxt = ST_IDLE;
              case (SC0)
                8'h75: begin key_vld = 1'b1; key_dir = DIR_UP;    end
                8'h72: begin key_vld = 1'b1; key_dir = DIR_DOWN;  end
                8'h6B: begin key_vld = 1'b1; key_dir = DIR_LEFT;  end
                8'h74: begin key_vld = 1'b1; key_dir = DIR_RIGHT; end
                default: ;
              endcase
            end
          endcase
        end
        // Byte after F0 (plain or extended) is a break code: consume silently.
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Parser state and the start pulse; clear is a game restart and leaves the
  // parser (and a concurrent Enter) alone.
  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      state <= ST_IDLE;
      start <= 1'b0;
    end else begin
      state <= state_nxt;
      start <= key_start;
    end
  end

  // New keys are judged against the last direction the snake will take: the
  // queue tail if anything is queued, else the live direction.
  assign tail_idx = wr_ptr - 1'b1;
  assign ref_dir  = (pending != '0) ? mem[tail_idx] : dir;
  assign full     = (pending == CW'(DEPTH));
  assign is_dup   = (key_dir == ref_dir);
  assign is_rev   = (key_dir == (ref_dir ^ 2'b01));
  assign pop      = step && (pending != '0);
  // A tick in the same cycle frees a slot, so a full queue can still accept.
  assign push     = key_vld && !is_dup && !is_rev && (!full || step);
  assign reject   = key_vld && !is_dup && (is_rev || (full && !step));

  // Queue bookkeeping: pointers, occupancy, applied direction, drop pulse.
  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      dir     <= DIR_UP;
      pending <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      drop    <= 1'b0;
    end else if (clear) begin
      dir     <= DIR_UP;
      pending <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      drop    <= 1'b0;
    end else begin
      drop <= reject;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        dir    <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: ;
      endcase
    end
  end

  // Queue storage; contents are only meaningful below `pending`, so no reset.
  always_ff @(posedge CLOCK_50) begin
    if (rst && !clear && push) mem[wr_ptr] <= key_dir;
  end

endmodule

// File: tb/tb_kb_dir_queue.sv
// Testbench for kb_dir_queue: scenario tasks drive PS/2 bytes, ticks and
// clears; expected directions are queued and popped as ticks apply them.
module tb_kb_dir_queue;

  logic       CLOCK_50;
  logic       rst;
  logic [7:0] SC0;
  logic       GotCode;
  logic       step;
  logic       clear;
  logic [1:0] dir;
  logic       start;
  logic [2:0] pending;
  logic       drop;

  int tests = 0;
  int fails = 0;

  logic [1:0] exp_q[$];
  logic [1:0] exp_dir;

  int   drop_cnt = 0, start_cnt = 0, width_err = 0;
  logic prev_drop = 1'b0, prev_start = 1'b0;

  logic [7:0] plain_code [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
  logic [7:0] ext_code   [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

  kb_dir_queue #(.DEPTH(4), .CW(3)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .SC0(SC0), .GotCode(GotCode),
    .step(step), .clear(clear), .dir(dir), .start(start),
    .pending(pending), .drop(drop)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse monitor: counts start/drop pulses and any pulse wider than 1 cycle.
  always @(negedge CLOCK_50) begin
    if (drop === 1'b1) drop_cnt++;
    if (start === 1'b1) start_cnt++;
    if (drop === 1'b1 && prev_drop === 1'b1) width_err++;
    if (start === 1'b1 && prev_start === 1'b1) width_err++;
    prev_drop  = drop;
    prev_start = start;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge CLOCK_50);
    rst = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    rst = 1'b1;
    @(negedge CLOCK_50);
  endtask

  // Send one scan byte; optionally tick on the cycle the byte takes effect.
  task automatic send_byte(input logic [7:0] b, input bit with_step,
                           output logic saw_drop, output logic saw_start);
    @(negedge CLOCK_50);
    SC0 = b;
    GotCode = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    if (with_step) step = 1'b1;
    @(negedge CLOCK_50);
    step = 1'b0;
    saw_drop  = drop;
    saw_start = start;
    @(negedge CLOCK_50);
    GotCode = 1'b1;
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic send(input logic [7:0] b);
    logic d, s;
    send_byte(b, 1'b0, d, s);
  endtask

  task automatic do_step(output logic [1:0] obs_dir, output logic [2:0] obs_pend);
    @(negedge CLOCK_50);
    step = 1'b1;
    @(negedge CLOCK_50);
    step = 1'b0;
    obs_dir  = dir;
    obs_pend = pending;
  endtask

  task automatic do_clear();
    @(negedge CLOCK_50);
    clear = 1'b1;
    @(negedge CLOCK_50);
    clear = 1'b0;
    exp_q.delete();
    exp_dir = 2'b00;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    tests++; if (dir !== 2'b00) begin fails++; $display("FAIL reset_dir: got %0d want 0", dir); end
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL reset_pending: got %0d want 0", pending); end
    tests++; if (start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b want 0", start); end
    tests++; if (drop !== 1'b0) begin fails++; $display("FAIL reset_drop: got %b want 0", drop); end
    exp_q.delete();
    exp_dir = 2'b00;
  endtask

  task automatic test_basic();
    logic [1:0] od; logic [2:0] op;
    send(8'h1C); exp_q.push_back(2'b10);
    tests++; if (pending !== 3'd1) begin fails++; $display("FAIL basic_pending: got %0d want 1", pending); end
    tests++; if (dir !== 2'b00) begin fails++; $display("FAIL basic_dir_before: got %0d want 0", dir); end
    do_step(od, op); exp_dir = exp_q.pop_front();
    tests++; if (od !== exp_dir) begin fails++; $display("FAIL basic_pop_dir: got %0d want %0d", od, exp_dir); end
    tests++; if (op !== 3'd0) begin fails++; $display("FAIL basic_pop_pending: got %0d want 0", op); end
  endtask

  task automatic test_reversal();
    logic d, s; int d0;
    do_clear();
    d0 = drop_cnt;
    send_byte(8'h1B, 1'b0, d, s);
    tests++; if (d !== 1'b1) begin fails++; $display("FAIL rev_drop: got %b want 1", d); end
    tests++; if (drop_cnt - d0 !== 1) begin fails++; $display("FAIL rev_drop_count: got %0d want 1", drop_cnt - d0); end
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL rev_pending: got %0d want 0", pending); end
    send_byte(8'h23, 1'b0, d, s);
    tests++; if (d !== 1'b0) begin fails++; $display("FAIL accept_drop: got %b want 0", d); end
    tests++; if (pending !== 3'd1) begin fails++; $display("FAIL accept_pending: got %0d want 1", pending); end
  endtask

  task automatic test_break_ext();
    logic [1:0] od; logic [2:0] op; int d0;
    do_clear();
    d0 = drop_cnt;
    send(8'hF0); send(8'h1C);
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL brk_plain: got %0d want 0", pending); end
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h6B);
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL brk_ext: got %0d want 0", pending); end
    send(8'hE0); send(8'h6B); exp_q.push_back(2'b10);
    tests++; if (pending !== 3'd1) begin fails++; $display("FAIL ext_left: got %0d want 1", pending); end
    send(8'h1C); send(8'h1C);
    tests++; if (pending !== 3'd1) begin fails++; $display("FAIL dup_pending: got %0d want 1", pending); end
    tests++; if (drop_cnt !== d0) begin fails++; $display("FAIL dup_drop: got %0d drops want 0", drop_cnt - d0); end
    // Double E0 stays extended; right on a left tail is a reversal.
    send(8'hE0); send(8'hE0); send(8'h74);
    tests++; if (drop_cnt - d0 !== 1) begin fails++; $display("FAIL ext_rev_drop: got %0d want 1", drop_cnt - d0); end
    do_step(od, op); exp_dir = exp_q.pop_front();
    tests++; if (od !== exp_dir) begin fails++; $display("FAIL ext_pop_dir: got %0d want %0d", od, exp_dir); end
  endtask

  task automatic test_full();
    logic d, s; logic [1:0] od; logic [2:0] op;
    do_clear();
    send(8'h1C); exp_q.push_back(2'b10);
    send(8'h1D); exp_q.push_back(2'b00);
    send(8'h23); exp_q.push_back(2'b11);
    send(8'h1D); exp_q.push_back(2'b00);
    tests++; if (pending !== 3'd4) begin fails++; $display("FAIL full_pending: got %0d want 4", pending); end
    send_byte(8'h1C, 1'b0, d, s);
    tests++; if (d !== 1'b1) begin fails++; $display("FAIL full_drop: got %b want 1", d); end
    tests++; if (pending !== 3'd4) begin fails++; $display("FAIL full_hold: got %0d want 4", pending); end
    send_byte(8'h1C, 1'b1, d, s);
    exp_dir = exp_q.pop_front(); exp_q.push_back(2'b10);
    tests++; if (d !== 1'b0) begin fails++; $display("FAIL full_step_drop: got %b want 0", d); end
    tests++; if (pending !== 3'd4) begin fails++; $display("FAIL full_step_pending: got %0d want 4", pending); end
    tests++; if (dir !== exp_dir) begin fails++; $display("FAIL full_step_dir: got %0d want %0d", dir, exp_dir); end
    for (int i = 0; i < 4; i++) begin
      do_step(od, op); exp_dir = exp_q.pop_front();
      tests++; if (od !== exp_dir) begin fails++; $display("FAIL drain_dir%0d: got %0d want %0d", i, od, exp_dir); end
      tests++; if (op !== 3'(3 - i)) begin fails++; $display("FAIL drain_pending%0d: got %0d want %0d", i, op, 3 - i); end
    end
  endtask

  task automatic test_start_clear();
    logic d, s; logic [1:0] od; logic [2:0] op; int s0;
    s0 = start_cnt;
    send_byte(8'h5A, 1'b0, d, s);
    tests++; if (s !== 1'b1) begin fails++; $display("FAIL start_pulse: got %b want 1", s); end
    tests++; if (start_cnt - s0 !== 1) begin fails++; $display("FAIL start_count: got %0d want 1", start_cnt - s0); end
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL start_queue: got %0d want 0", pending); end
    send(8'h1D); send(8'h23); send(8'h1D);
    tests++; if (pending !== 3'd3) begin fails++; $display("FAIL pre_clear_pending: got %0d want 3", pending); end
    do_clear();
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL clear_pending: got %0d want 0", pending); end
    tests++; if (dir !== 2'b00) begin fails++; $display("FAIL clear_dir: got %0d want 0", dir); end
    do_step(od, op);
    tests++; if (od !== 2'b00 || op !== 3'd0) begin fails++; $display("FAIL empty_step: got dir %0d pend %0d want 0 0", od, op); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] od; logic [2:0] op;
    send(8'h1C);
    do_step(od, op);
    send(8'h1D);
    send(8'hE0);
    do_reset(); exp_q.delete(); exp_dir = 2'b00;
    tests++; if (dir !== 2'b00 || pending !== 3'd0) begin fails++; $display("FAIL midreset_outputs: got dir %0d pend %0d want 0 0", dir, pending); end
    send(8'h75);
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL midreset_75: got %0d want 0", pending); end
    send(8'hE0);
    do_reset();
    send(8'h6B);
    tests++; if (pending !== 3'd0) begin fails++; $display("FAIL midreset_6B: got %0d want 0", pending); end
  endtask

  // Random key/tick mix checked against a queue model of the enqueue rules.
  task automatic test_random();
    logic d, s; logic [1:0] k, ref_d, od; logic [2:0] op;
    bit ext, stp, exp_drop;
    do_clear();
    for (int i = 0; i < 30; i++) begin
      k   = 2'($urandom_range(0, 3));
      ext = ($urandom_range(0, 1) == 1);
      stp = ($urandom_range(0, 2) == 0);
      ref_d = (exp_q.size() > 0) ? exp_q[$] : exp_dir;
      exp_drop = 1'b0;
      if (ext) send(8'hE0);
      send_byte(ext ? ext_code[k] : plain_code[k], stp, d, s);
      if (stp && exp_q.size() > 0) exp_dir = exp_q.pop_front();
      if (k != ref_d) begin
        if (k == (ref_d ^ 2'b01)) exp_drop = 1'b1;
        else if (exp_q.size() == 4 && !stp) exp_drop = 1'b1;
        else exp_q.push_back(k);
      end
      tests++; if (d !== exp_drop) begin fails++; $display("FAIL rnd_drop%0d: got %b want %b", i, d, exp_drop); end
      tests++; if (pending !== 3'(exp_q.size())) begin fails++; $display("FAIL rnd_pending%0d: got %0d want %0d", i, pending, exp_q.size()); end
      tests++; if (dir !== exp_dir) begin fails++; $display("FAIL rnd_dir%0d: got %0d want %0d", i, dir, exp_dir); end
    end
    while (exp_q.size() > 0) begin
      do_step(od, op); exp_dir = exp_q.pop_front();
      tests++; if (od !== exp_dir) begin fails++; $display("FAIL rnd_drain: got %0d want %0d", od, exp_dir); end
    end
  endtask

  task automatic test_pulse_width();
    tests++; if (width_err !== 0) begin fails++; $display("FAIL pulse_width: got %0d wide pulses want 0", width_err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0; SC0 = 8'h00; GotCode = 1'b1; step = 1'b0; clear = 1'b0;
    exp_dir = 2'b00;
    test_reset();
    test_basic();
    test_reversal();
    test_break_ext();
    test_full();
    test_start_clear();
    test_reset_mid();
    test_random();
    test_pulse_width();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
